// File: rtl/ov7670_stream_capture.sv
// ov7670_stream_capture
// OV7670 capture front end, entirely in the sensor pixel-clock domain.
// Assembles raw sensor bytes into 1- or 2-byte pixels, tags each pixel with
// its x/y coordinate, and emits frame/line markers plus a sticky
// line-length error flag.
// Optional feature macro: OV7670_CAPTURE_DECIMATE_EN (2:1 decimation in both
// axes; only even sensor pixels of even sensor lines are emitted).

module ov7670_stream_capture #(
  parameter int BYTES_PER_PIX = 2,
  parameter int H_ACTIVE      = 640,
  parameter int V_ACTIVE      = 480,
  parameter int COORD_W       = 10
) (
  input  logic                       pclk_12,
  input  logic                       reset_n,
  input  logic                       start,
  input  logic                       vsync,
  input  logic                       href,
  input  logic [7:0]                 d,
  output logic [8*BYTES_PER_PIX-1:0] pix_data,
  output logic                       pix_valid,
  output logic [COORD_W-1:0]         pix_x,
  output logic [COORD_W-1:0]         pix_y,
  output logic                       line_start,
  output logic                       frame_start,
  output logic                       frame_done,
  output logic                       busy,
  output logic                       line_err
);

  localparam int                 PIX_W   = 8 * BYTES_PER_PIX;
  localparam logic [COORD_W-1:0] H_LIM   = COORD_W'(H_ACTIVE);
  localparam logic [COORD_W-1:0] V_LIM   = COORD_W'(V_ACTIVE);
  localparam logic [COORD_W-1:0] CNT_MAX = '1;
  localparam logic [COORD_W-1:0] CNT_ONE = COORD_W'(1);

  typedef enum logic [1:0] {IDLE, SYNC, ACTIVE} state_t;

  state_t state, state_next;

  logic       vsync_r, href_r, vsync_d, href_d;
  logic [7:0] d_r;
  logic       start_s1, start_s2;

  logic vs_rise, vs_fall, hr_rise, hr_fall;
  logic frame_start_ev, frame_done_ev;

  logic             pix_done;   // a complete sensor pixel is on d_r this cycle
  logic [PIX_W-1:0] pix_word;
  logic             odd_bytes;  // byte phase after this cycle (1 = half pixel pending)
  logic             keep_pix;   // sensor pixel survives decimation
  logic             keep_line;  // sensor line survives decimation

  logic [COORD_W-1:0] x_cnt, x_eff, x_next;
  logic [COORD_W-1:0] y_cnt, y_next;
  logic               first_pend, first_eff;
  logic               x_inc, y_inc, emit, line_close;
  logic               err_line, err_frame;

  // Input registers, edge-detect delay taps and the start synchroniser
  always_ff @(posedge pclk_12 or negedge reset_n) begin
    if (!reset_n) begin
      vsync_r  <= 1'b0;
      href_r   <= 1'b0;
      d_r      <= 8'h00;
      vsync_d  <= 1'b0;
      href_d   <= 1'b0;
      start_s1 <= 1'b0;
      start_s2 <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments make every flop sample pre-edge values,
      // so the delay taps and synchroniser stages really are one cycle apart.
      vsync_r  <= vsync;
      href_r   <= href;
      d_r      <= d;
      vsync_d  <= vsync_r;
      href_d   <= href_r;
      start_s1 <= start;
      start_s2 <= start_s1;
    end
  end

  assign vs_rise =  vsync_r & ~vsync_d;
  assign vs_fall = ~vsync_r &  vsync_d;
  assign hr_rise =  href_r  & ~href_d;
  assign hr_fall = ~href_r  &  href_d;

  // Capture state register
  always_ff @(posedge pclk_12 or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_next;
  end

  // Next-state logic and frame boundary events
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path
    // leaves it unassigned and no latch is inferred.
    state_next     = state;
    frame_start_ev = 1'b0;
    frame_done_ev  = 1'b0;
    case (state)
      IDLE: begin
        if (start_s2) state_next = SYNC;
      end
      SYNC: begin
        if (!start_s2) begin
          state_next = IDLE;
        end else if (vs_fall) begin
          state_next     = ACTIVE;
          frame_start_ev = 1'b1;
        end
      end
      ACTIVE: begin
        // Dropping start mid-frame only takes effect at the frame end.
        if (vs_rise) begin
          frame_done_ev = 1'b1;
          state_next    = start_s2 ? SYNC : IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign busy = (state != IDLE);

  // Byte assembly
  if (BYTES_PER_PIX == 2) begin : g_two_byte
    logic       phase, phase_eff;
    logic [7:0] hi_byte;

    // A new line always starts on a high byte, whatever the old phase was.
    assign phase_eff = hr_rise ? 1'b0 : phase;
    assign pix_done  = href_r & phase_eff;
    assign pix_word  = {hi_byte, d_r};
    assign odd_bytes = href_r ? ~phase_eff : phase;

    // Byte phase: toggles on every href-high cycle
    always_ff @(posedge pclk_12 or negedge reset_n) begin
      if (!reset_n) phase <= 1'b0;
      else          phase <= odd_bytes;
    end

    // High-byte holding register
    // NOTE: pure data register with no reset; its value only reaches
    // pix_data behind a completed pixel, so the power-up value never matters.
    always_ff @(posedge pclk_12) begin
      if (href_r && !phase_eff) hi_byte <= d_r;
    end
  end else begin : g_one_byte
    assign pix_done  = href_r;
    assign pix_word  = d_r;
    assign odd_bytes = 1'b0;
  end

`ifdef OV7670_CAPTURE_DECIMATE_EN
  logic sx_odd, sx_eff, sy_odd;

  assign sx_eff    = hr_rise ? 1'b0 : sx_odd;
  assign keep_pix  = ~sx_eff;
  assign keep_line = ~sy_odd;

  // Sensor pixel/line parity for 2:1 decimation
  always_ff @(posedge pclk_12 or negedge reset_n) begin
    if (!reset_n) begin
      sx_odd <= 1'b0;
      sy_odd <= 1'b0;
    end else begin
      if (pix_done)     sx_odd <= ~sx_eff;
      else if (hr_rise) sx_odd <= 1'b0;
      if (frame_start_ev)  sy_odd <= 1'b0;
      else if (line_close) sy_odd <= ~sy_odd;
    end
  end
`else
  assign keep_pix  = 1'b1;
  assign keep_line = 1'b1;
`endif

  // Pixel/line counters in output units; they saturate so an overlong line
  // or frame still reads as "not equal" at the check instead of wrapping.
  assign x_eff     = hr_rise ? '0 : x_cnt;
  assign x_inc     = pix_done & keep_pix;
  assign x_next    = (x_inc && x_eff != CNT_MAX) ? x_eff + CNT_ONE : x_eff;
  assign first_eff = hr_rise | first_pend;

  assign emit = (state == ACTIVE) && x_inc && keep_line &&
                (x_eff < H_LIM) && (y_cnt < V_LIM);

  // A vsync rise with href still high closes the open line in the same cycle.
  assign line_close = (state == ACTIVE) && (hr_fall || (vs_rise && href_r));
  assign y_inc      = line_close & keep_line;
  assign y_next     = (y_inc && y_cnt != CNT_MAX) ? y_cnt + CNT_ONE : y_cnt;

  assign err_line  = line_close && ((x_next != H_LIM) || odd_bytes);
  assign err_frame = frame_done_ev && (y_next != V_LIM);

  // Counter and first-pixel-of-line tracking
  always_ff @(posedge pclk_12 or negedge reset_n) begin
    if (!reset_n) begin
      x_cnt      <= '0;
      y_cnt      <= '0;
      first_pend <= 1'b0;
    end else begin
      x_cnt      <= x_next;
      y_cnt      <= frame_start_ev ? '0 : y_next;
      first_pend <= first_eff & ~emit;
    end
  end

  // Registered outputs: pixel strobe, coordinates, markers and sticky error
  always_ff @(posedge pclk_12 or negedge reset_n) begin
    if (!reset_n) begin
      pix_data    <= '0;
      pix_valid   <= 1'b0;
      pix_x       <= '0;
      pix_y       <= '0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
      frame_done  <= 1'b0;
      line_err    <= 1'b0;
    end else begin
      pix_valid   <= emit;
      line_start  <= emit & first_eff;
      frame_start <= frame_start_ev;
      frame_done  <= frame_done_ev;
      if (emit) begin
        pix_data <= pix_word;
        pix_x    <= x_eff;
        pix_y    <= y_cnt;
      end else if (frame_start_ev) begin
        pix_y <= '0;
      end
      // The frame_start clear takes priority over a coincident set.
      if (frame_start_ev)             line_err <= 1'b0;
      else if (err_line || err_frame) line_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_ov7670_stream_capture.sv
// tb_ov7670_stream_capture
// Randomised frames against a behavioural frame model: expected pixels,
// coordinates, markers and line_err are derived from the raw byte lists.
`timescale 1ns/1ps

module tb_ov7670_stream_capture;

  localparam int BPP = 2;
  localparam int H   = 4;
  localparam int V   = 3;
  localparam int CW  = 4;
  localparam int PW  = 8 * BPP;
`ifdef OV7670_CAPTURE_DECIMATE_EN
  localparam int DEC = 2;
`else
  localparam int DEC = 1;
`endif
  localparam int LINE_BYTES = H * DEC * BPP;

  logic          pclk_12 = 1'b0;
  logic          reset_n = 1'b0;
  logic          start   = 1'b0;
  logic          vsync   = 1'b1;
  logic          href    = 1'b0;
  logic [7:0]    d       = 8'h00;
  logic [PW-1:0] pix_data;
  logic          pix_valid;
  logic [CW-1:0] pix_x, pix_y;
  logic          line_start, frame_start, frame_done, busy, line_err;

  ov7670_stream_capture #(
    .BYTES_PER_PIX(BPP), .H_ACTIVE(H), .V_ACTIVE(V), .COORD_W(CW)
  ) dut (
    .pclk_12(pclk_12), .reset_n(reset_n), .start(start), .vsync(vsync),
    .href(href), .d(d), .pix_data(pix_data), .pix_valid(pix_valid),
    .pix_x(pix_x), .pix_y(pix_y), .line_start(line_start),
    .frame_start(frame_start), .frame_done(frame_done), .busy(busy),
    .line_err(line_err)
  );

  always #5 pclk_12 = ~pclk_12;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  typedef struct packed {
    logic [PW-1:0] data;
    logic [CW-1:0] x;
    logic [CW-1:0] y;
    logic          ls;
  } pix_t;

  pix_t obs_q[$];
  pix_t exp_q[$];
  pix_t mon_p;
  int   n_fs, n_fd, n_fs_err, n_ls_orphan;

  // Monitor: sample outputs on the falling edge
  always @(negedge pclk_12) begin
    if (pix_valid) begin
      mon_p.data = pix_data;
      mon_p.x    = pix_x;
      mon_p.y    = pix_y;
      mon_p.ls   = line_start;
      obs_q.push_back(mon_p);
    end
    if (line_start && !pix_valid) n_ls_orphan++;
    if (frame_start) begin
      n_fs++;
      if (line_err) n_fs_err++;
    end
    if (frame_done) n_fd++;
  end

  // Frame under construction: flat byte list plus bytes-per-line list
  logic [7:0] fr_bytes[$];
  int         fr_len[$];
  logic       exp_err = 1'b0;

  task automatic tick(input int n);
    repeat (n) @(negedge pclk_12);
  endtask

  task automatic gen_line(input int nbytes, input bit ramp);
    fr_len.push_back(nbytes);
    for (int i = 0; i < nbytes; i++)
      fr_bytes.push_back(ramp ? 8'(i + 1) : 8'($urandom_range(0, 255)));
  endtask

  task automatic gen_good_frame();
    for (int l = 0; l < V * DEC; l++) gen_line(LINE_BYTES, 1'b0);
  endtask

  // Reference: which pixels a frame should produce and whether it is malformed
  task automatic model_frame(output logic err);
    int   base, npix, kept;
    bit   first;
    pix_t p;
    base = 0;
    err  = 1'b0;
    exp_q.delete();
    for (int ly = 0; ly < fr_len.size(); ly++) begin
      npix  = fr_len[ly] / BPP;
      kept  = (npix + DEC - 1) / DEC;
      first = 1'b1;
      if ((ly % DEC) == 0 && (ly / DEC) < V) begin
        for (int px = 0; px < npix && (px / DEC) < H; px += DEC) begin
          p.data = {fr_bytes[base + 2*px], fr_bytes[base + 2*px + 1]};
          p.x    = CW'(px / DEC);
          p.y    = CW'(ly / DEC);
          p.ls   = first;
          first  = 1'b0;
          exp_q.push_back(p);
        end
      end
      if (kept != H || (fr_len[ly] % BPP) != 0) err = 1'b1;
      base += fr_len[ly];
    end
    if ((fr_len.size() + DEC - 1) / DEC != V) err = 1'b1;
  endtask

  task automatic drive_frame(input int drop_line);
    int base;
    base  = 0;
    vsync = 1'b1; href = 1'b0; tick(4);
    vsync = 1'b0; tick(3);
    for (int ly = 0; ly < fr_len.size(); ly++) begin
      if (ly == drop_line) start = 1'b0;
      href = 1'b1;
      for (int i = 0; i < fr_len[ly]; i++) begin
        d = fr_bytes[base + i];
        tick(1);
      end
      href = 1'b0; d = 8'h00; tick(3);
      base += fr_len[ly];
    end
    vsync = 1'b1; tick(6);
  endtask

  task automatic run_frame(input string tag, input bit capture, input int drop_line);
    logic ferr;
    obs_q.delete();
    n_fs = 0; n_fd = 0; n_fs_err = 0; n_ls_orphan = 0;
    model_frame(ferr);
    drive_frame(drop_line);
    if (!capture) exp_q.delete();
    else          exp_err = ferr;
    check({tag, "/npix"}, obs_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++)
      check($sformatf("%s/pix%0d", tag, i), obs_q[i], exp_q[i]);
    check({tag, "/frame_start"}, n_fs, capture);
    check({tag, "/frame_done"}, n_fd, capture);
    check({tag, "/line_err"}, line_err, exp_err);
    check({tag, "/err_at_fs"}, n_fs_err, 0);
    check({tag, "/orphan_ls"}, n_ls_orphan, 0);
    check({tag, "/busy"}, busy, start);
    fr_bytes.delete();
    fr_len.delete();
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "/pix_data"}, pix_data, 0);
    check({tag, "/pix_valid"}, pix_valid, 0);
    check({tag, "/pix_x"}, pix_x, 0);
    check({tag, "/pix_y"}, pix_y, 0);
    check({tag, "/line_start"}, line_start, 0);
    check({tag, "/frame_start"}, frame_start, 0);
    check({tag, "/frame_done"}, frame_done, 0);
    check({tag, "/busy"}, busy, 0);
    check({tag, "/line_err"}, line_err, 0);
  endtask

  initial begin
    #500us;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int nl, nb, pick;

    tick(3);
    check_all_zero("reset");
    reset_n = 1'b1;
    tick(2);

    // start reaches SYNC on the third rising edge
    start = 1'b1;
    @(posedge pclk_12); #1;
    @(posedge pclk_12); #1;
    check("start/edge2_busy", busy, 0);
    @(posedge pclk_12); #1;
    check("start/edge3_busy", busy, 1);
    tick(2);

    // Directed ramp line 01 02 03 ..., remaining lines random
    gen_line(LINE_BYTES, 1'b1);
    for (int l = 1; l < V * DEC; l++) gen_line(LINE_BYTES, 1'b0);
    run_frame("rgb565", 1'b1, -1);

    // Odd byte count on the first line
    gen_line(LINE_BYTES - 1, 1'b0);
    for (int l = 1; l < V * DEC; l++) gen_line(LINE_BYTES, 1'b0);
    run_frame("odd", 1'b1, -1);

    // Clean frame: error must clear at frame_start
    gen_good_frame();
    run_frame("clear", 1'b1, -1);

    // Overlong line: clipped to H pixels
    gen_line((H + 2) * DEC * BPP, 1'b0);
    for (int l = 1; l < V * DEC; l++) gen_line(LINE_BYTES, 1'b0);
    run_frame("clip", 1'b1, -1);

    // Random frames: line counts and line lengths around nominal
    for (int f = 0; f < 6; f++) begin
      nl = V * DEC + $urandom_range(0, 2) - 1;
      for (int l = 0; l < nl; l++) begin
        pick = $urandom_range(0, 7);
        case (pick)
          0:       nb = LINE_BYTES - 1;
          1:       nb = LINE_BYTES + 1;
          2:       nb = LINE_BYTES - BPP;
          3:       nb = LINE_BYTES + 2 * BPP;
          default: nb = LINE_BYTES;
        endcase
        gen_line(nb, 1'b0);
      end
      run_frame($sformatf("rand%0d", f), 1'b1, -1);
    end

    // start dropped during line 1: frame completes, then capture stops
    gen_good_frame();
    run_frame("drop", 1'b1, 1);
    gen_good_frame();
    run_frame("idle", 1'b0, -1);

    // Reset in the middle of an active line
    start = 1'b1;
    tick(4);
    vsync = 1'b1; tick(4);
    vsync = 1'b0; tick(3);
    href = 1'b1;
    for (int i = 0; i < LINE_BYTES; i++) begin
      d = 8'($urandom_range(0, 255));
      tick(1);
    end
    href = 1'b0; tick(3);
    href = 1'b1;
    for (int i = 0; i < LINE_BYTES - 2; i++) begin
      d = 8'($urandom_range(0, 255));
      tick(1);
    end
    check("midrst/busy_before", busy, 1);
    #2 reset_n = 1'b0;
    #1 check_all_zero("midrst");
    start = 1'b0; href = 1'b0; vsync = 1'b1;
    tick(3);
    reset_n = 1'b1;
    exp_err = 1'b0;
    tick(4);
    check("midrst/busy_after", busy, 0);
    gen_good_frame();
    run_frame("post_rst", 1'b0, -1);
    start = 1'b1;
    tick(4);
    gen_good_frame();
    run_frame("restart", 1'b1, -1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/ov7670_stream_capture.md
# ov7670_stream_capture

Parametrised pixel-capture front end for the OV7670 sensor, running entirely in the sensor pixel-clock domain. It assembles raw sensor bytes into 1- or 2-byte pixels and tags each pixel with its x/y coordinate. It also emits frame/line markers and line-length error status. It sits between the sensor pins and the line-buffer controller / framebuffer writer.

## Interface
- BYTES_PER_PIX, default 2: bytes per pixel; 1 (raw/Y) or 2 (RGB565, high byte first).
- H_ACTIVE, default 640: expected pixels per line, counted after optional decimation.
- V_ACTIVE, default 480: expected lines per frame, counted after optional decimation.
- COORD_W, default 10: width of the coordinate outputs; must satisfy 2^COORD_W > max(H_ACTIVE, V_ACTIVE).

- pclk_12 in 1: sensor pixel clock; sole clock.
- reset_n in 1: reset, asynchronous active-low.
- start in 1: capture enable from the configuration domain; level-sensitive; 2-flop synchronised internally.
- vsync in 1: sensor vertical sync, high during vertical blanking.
- href in 1: sensor line-valid.
- d in 8: sensor data.
- pix_data out 8*BYTES_PER_PIX: assembled pixel.
- pix_valid out 1: one-cycle strobe qualifying pix_data, pix_x and pix_y.
- pix_x out COORD_W: column of the current pixel.
- pix_y out COORD_W: row of the current pixel.
- line_start out 1: one-cycle pulse at the start of each emitted line.
- frame_start out 1: one-cycle pulse at the start of each captured frame.
- frame_done out 1: one-cycle pulse at the end of each captured frame.
- busy out 1: high in states SYNC and ACTIVE.
- line_err out 1: sticky flag; cleared by frame_start.

## Operation
- Input stage: vsync, href and d are registered once (vsync_r, href_r, d_r); all logic operates on the registered copies.
- Edge detection: each of vsync_r and href_r is compared with its own one-cycle-delayed copy to give rise and fall events.
- States:
  - IDLE: waiting for capture enable.
  - SYNC: waiting for frame alignment.
  - ACTIVE: capturing a frame.
- Transitions:
  - IDLE→SYNC when the synchronised start is 1.
  - SYNC→ACTIVE on a vsync_r fall; frame_start pulses.
  - ACTIVE→SYNC on a vsync_r rise when start is still 1; frame_done pulses.
  - ACTIVE→IDLE on a vsync_r rise when start is 0; frame_done pulses.
  - Deasserting start mid-frame does not abort; the current frame completes first.
  - SYNC→IDLE when start is 0.
- Byte assembly, BYTES_PER_PIX=2:
  - A phase bit toggles on every href_r-high cycle.
  - Phase 0 latches the high byte.
  - Phase 1 emits {high, d_r}.
  - Phase resets to 0 on every href_r rise.
- Byte assembly, BYTES_PER_PIX=1: every href_r-high cycle emits d_r.
- Coordinates:
  - pix_x resets to 0 at the href_r rise and increments after each emitted pixel.
  - pix_y resets to 0 at frame_start and increments on each href_r fall that closes an emitted line.
- Clipping: pixels with x ≥ H_ACTIVE or lines with y ≥ V_ACTIVE are dropped (no pix_valid); counters saturate, never wrap.
- line_err is set when any of the following occurs:
  - an href_r fall with a pixel count ≠ H_ACTIVE;
  - an href_r fall with phase = 1 (odd byte count);
  - frame_done with a line count ≠ V_ACTIVE.
- Coincident events:
  - If vsync_r rises while href_r is high, the line is closed first and frame_done follows in the same cycle.
  - If line_err set and frame_start coincide, frame_start's clear wins.

## Timing
- Reset values: pix_data 0, pix_valid 0, pix_x 0, pix_y 0, line_start 0, frame_start 0, frame_done 0, busy 0, line_err 0, state IDLE, phase 0.
- Latency: the byte completing a pixel, present on d at edge k, produces pix_valid=1 in the cycle after edge k+1.
- line_start pulses together with the first pix_valid of the line.
- frame_start pulses the cycle after the vsync_r fall is detected.
- start to SYNC: 3 edges (2 synchroniser stages + 1 state update).
- Pixel rate: pix_valid duty ≤ 1/BYTES_PER_PIX; there is no backpressure and the downstream must accept every strobe.

## Configuration
- OV7670_CAPTURE_DECIMATE_EN defined: 2:1 decimation in both axes (VGA sensor → QVGA stream).
  - Only even-indexed sensor pixels of even-indexed sensor lines are emitted.
  - pix_x, pix_y, H_ACTIVE and V_ACTIVE are in decimated units.
  - line_start pulses only for emitted lines.
- OV7670_CAPTURE_DECIMATE_EN undefined: every pixel of every line is emitted; the decimation counters are not instantiated.

## Test plan
- Reset mid-frame: assert reset_n=0 during an active line → all outputs read 0 immediately (asynchronously); after release, state is IDLE and no pix_valid appears until start is set and a vsync fall is seen.
- RGB565 pixel assembly: BYTES_PER_PIX=2, H_ACTIVE=4, one line of bytes 01 02 03 04 05 06 07 08 → pix_data 0x0102, 0x0304, 0x0506, 0x0708 with pix_x 0..3; line_start with the first pixel; line_err stays 0.
- Odd byte count: a line of 7 bytes with H_ACTIVE=4 → 3 pixels emitted; line_err=1 after the href fall; line_err cleared at the next frame_start.
- Clipping: a 6-pixel line with H_ACTIVE=4 → exactly 4 pix_valid; pix_x never exceeds 3; line_err=1.
- start dropped mid-frame: deassert start during line 1 of a 3-line frame with V_ACTIVE=3 → all 3 lines are emitted, frame_done pulses once, busy falls, and the next frame produces no output.
- Decimation (macro defined): a 4×4 sensor frame of byte values equal to the index, BYTES_PER_PIX=1, H_ACTIVE=2, V_ACTIVE=2 → 4 pixels emitted from sensor (0,0), (2,0), (0,2), (2,2) with coordinates (0,0), (1,0), (0,1), (1,1); line_err=0.
